dma_move_ctrl: RTL and testbench

DMA_MOVE_CTRL -- requirements
Module: dma_move_ctrl

---
 rtl/dma_move_pkg.sv | 15 +
 rtl/dma_move_cnt.sv | 42 ++++
 rtl/dma_move_ctrl.sv | 172 +++++++++++++++++
 tb/tb_dma_move_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_move_pkg.sv
// Shared types and constants for the DMA move controller.
package dma_move_pkg;

   localparam int DW_DEF     = 64;
   localparam int CW_DEF     = 24;
   localparam int BYTE_SHIFT = 3;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_FLUSH = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/dma_move_cnt.sv
// Remaining-word counter: synchronous clear, load, decrement, zero/one detect.
module dma_move_cnt #(
   parameter int WIDTH = 22
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             dec,
   output logic [WIDTH-1:0] cnt,
   output logic             zero,
   output logic             one
);

   logic [WIDTH-1:0] cnt_q;
   logic [WIDTH-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (load) begin
         cnt_d = load_val;
      end else if (dec && (cnt_q != '0)) begin
         cnt_d = cnt_q - WIDTH'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt  = cnt_q;
   assign zero = (cnt_q == '0);
   assign one  = (cnt_q == WIDTH'(1));

endmodule

// File: rtl/dma_move_ctrl.sv
// Moves a byte-counted block of words from a source FIFO to a destination FIFO.
//   state | meaning
//   IDLE  | waiting for start
//   RUN   | issuing gets and forwarding words
//   FLUSH | all gets issued, last put outstanding
//   DONE  | one-cycle completion pulse
module dma_move_ctrl
   import dma_move_pkg::*;
#(
   parameter int DW = DW_DEF,
   parameter int CW = CW_DEF
) (
   input  logic          wb_clk_i,
   input  logic          wb_rst_i,
   input  logic          start,
   input  logic [CW-1:0] dc1,
   input  logic          m_reset1,
   output logic          busy,
   output logic          done,
   output logic          err,
   output logic          m_src_getn,
   input  logic [DW-1:0] m_src,
   input  logic          m_src_last,
   input  logic          m_src_empty,
   input  logic          m_src_almost_empty,
   output logic          m_dst_putn,
   output logic [DW-1:0] m_dst,
   output logic          m_dst_last,
   input  logic          m_dst_full,
   input  logic          m_dst_almost_full
);

   localparam int WCW = CW + 1 - BYTE_SHIFT;

   state_t state_q, state_d;
   logic   getn_q, getn_d;
   logic   putn_q, putn_d;
   logic   busy_q, busy_d;
   logic   done_q, done_d;
   logic   err_q, err_d;

   logic           cnt_clr, cnt_load, rd_dec, wr_dec;
   logic [CW:0]    dc_round;
   logic [WCW-1:0] wc;
   logic [WCW-1:0] rd_rem, wr_rem;
   logic           rd_zero, rd_one, wr_zero, wr_one;
   logic           put_now, can_get, early_last;
   logic           unused_ok;

   // Extra top bit keeps the round-up from wrapping at the largest byte count.
   assign dc_round = {1'b0, dc1} + (CW+1)'((1 << BYTE_SHIFT) - 1);
   assign wc       = dc_round[CW:BYTE_SHIFT];

   assign put_now    = ~putn_q;
   assign can_get    = ~m_src_empty & ~m_dst_almost_full & ~m_dst_full & ~rd_zero;
   assign early_last = put_now & m_src_last & ~wr_one;
   assign wr_dec     = put_now;

   dma_move_cnt #(.WIDTH(WCW)) u_rd_cnt (
      .clk      (wb_clk_i),
      .rst      (wb_rst_i),
      .clr      (cnt_clr),
      .load     (cnt_load),
      .load_val (wc),
      .dec      (rd_dec),
      .cnt      (rd_rem),
      .zero     (rd_zero),
      .one      (rd_one)
   );

   dma_move_cnt #(.WIDTH(WCW)) u_wr_cnt (
      .clk      (wb_clk_i),
      .rst      (wb_rst_i),
      .clr      (cnt_clr),
      .load     (cnt_load),
      .load_val (wc),
      .dec      (wr_dec),
      .cnt      (wr_rem),
      .zero     (wr_zero),
      .one      (wr_one)
   );

   always_comb begin
      state_d  = state_q;
      getn_d   = 1'b1;
      putn_d   = 1'b1;
      err_d    = err_q;
      cnt_load = 1'b0;
      cnt_clr  = 1'b0;
      rd_dec   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               cnt_load = 1'b1;
               err_d    = 1'b0;
               state_d  = (wc == '0) ? ST_DONE : ST_RUN;
            end
         end
         ST_RUN: begin
            if (early_last) begin
               err_d   = 1'b1;
               state_d = ST_DONE;
            end else begin
               putn_d = getn_q;
               getn_d = ~can_get;
               rd_dec = can_get;
               if (put_now && wr_one) begin
                  state_d = ST_DONE;
               end else if (rd_zero) begin
                  state_d = ST_FLUSH;
               end
            end
         end
         ST_FLUSH: begin
            if (early_last) begin
               err_d   = 1'b1;
               state_d = ST_DONE;
            end else begin
               putn_d = getn_q;
               if (put_now && wr_one) begin
                  state_d = ST_DONE;
               end
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
      // Abort drops any word still in flight and overrides a same-cycle start.
      if (m_reset1) begin
         state_d  = ST_IDLE;
         getn_d   = 1'b1;
         putn_d   = 1'b1;
         err_d    = err_q;
         cnt_load = 1'b0;
         rd_dec   = 1'b0;
         cnt_clr  = 1'b1;
      end
      busy_d = (state_d == ST_RUN) || (state_d == ST_FLUSH);
      done_d = (state_d == ST_DONE);
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state_q <= ST_IDLE;
         getn_q  <= 1'b1;
         putn_q  <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         getn_q  <= getn_d;
         putn_q  <= putn_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   assign busy       = busy_q;
   assign done       = done_q;
   assign err        = err_q;
   assign m_src_getn = getn_q;
   assign m_dst_putn = putn_q;
   assign m_dst      = m_src;
   // The source tag arrives with the data, so it rides along with the word.
   assign m_dst_last = put_now & (wr_one | m_src_last);

   assign unused_ok = &{1'b0, m_src_almost_empty, rd_one, wr_zero, rd_rem, wr_rem,
                        dc_round[BYTE_SHIFT-1:0]};

endmodule

// File: tb/tb_dma_move_ctrl.sv
// Scoreboard bench for dma_move_ctrl: reference model queues expected words, monitor checks puts/done.
module tb_dma_move_ctrl;

   typedef struct packed {
      logic [63:0] d;
      logic        l;
   } wexp_t;

   typedef struct {
      logic err;
      bit   zero;
      int   sc;
   } dexp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [23:0] dc1_i;
   logic        m_reset1;
   logic        busy, done, err;
   logic        m_src_getn;
   logic [63:0] m_src;
   logic        m_src_last;
   logic        m_src_empty;
   logic        m_src_almost_empty;
   logic        m_dst_putn;
   logic [63:0] m_dst;
   logic        m_dst_last;
   logic        m_dst_full;
   logic        m_dst_almost_full;

   int    total = 0;
   int    bad   = 0;
   int    cyc   = 0;
   wexp_t src_q[$];
   wexp_t exp_q[$];
   dexp_t dq[$];
   int    af_mode  = 0;
   bit    stall_en = 0;
   bit    burst_chk = 0;
   logic [2:0] snap;
   int    job_puts = 0;
   int    first_put = 0;
   int    last_put  = 0;

   dma_move_ctrl #(.DW(64), .CW(24)) dut (
      .wb_clk_i           (clk),
      .wb_rst_i           (rst),
      .start              (start),
      .dc1                (dc1_i),
      .m_reset1           (m_reset1),
      .busy               (busy),
      .done               (done),
      .err                (err),
      .m_src_getn         (m_src_getn),
      .m_src              (m_src),
      .m_src_last         (m_src_last),
      .m_src_empty        (m_src_empty),
      .m_src_almost_empty (m_src_almost_empty),
      .m_dst_putn         (m_dst_putn),
      .m_dst              (m_dst),
      .m_dst_last         (m_dst_last),
      .m_dst_full         (m_dst_full),
      .m_dst_almost_full  (m_dst_almost_full)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input longint unsigned act, input longint unsigned exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic fail_evt(input string nm);
      total++;
      bad++;
      $display("FAIL %s: event with nothing expected (cycle %0d)", nm, cyc);
   endtask

   always @(posedge clk) begin
      cyc++;
      snap = {m_src_empty, m_dst_almost_full, m_dst_full};
      if (!rst && !m_src_getn) begin
         if (src_q.size() > 0) begin
            wexp_t w;
            w = src_q.pop_front();
            m_src      <= w.d;
            m_src_last <= w.l;
         end else begin
            m_src      <= 64'hdead_beef_dead_beef;
            m_src_last <= 1'b0;
         end
      end
   end

   // Source/destination status for the coming edge; empty accounts for a pop already requested.
   always @(negedge clk) begin
      int eff;
      eff = src_q.size() - (m_src_getn ? 0 : 1);
      m_src_empty = (stall_en && ($urandom_range(0, 3) == 0)) || (eff <= 0);
      case (af_mode)
         1:       m_dst_almost_full = ((cyc / 2) % 2) == 1;
         2:       m_dst_almost_full = ($urandom_range(0, 3) == 0);
         default: m_dst_almost_full = 1'b0;
      endcase
   end

   always @(negedge clk) begin
      if (!rst) begin
         if (!m_src_getn) begin
            chk("get_flags", snap, 3'b000);
            chk("get_busy", busy, 1);
         end
         if (!m_dst_putn) begin
            chk("put_full", m_dst_full, 0);
            if (exp_q.size() == 0) begin
               fail_evt("unexpected_put");
            end else begin
               wexp_t e;
               e = exp_q.pop_front();
               chk("put_data", m_dst, e.d);
               chk("put_last", m_dst_last, e.l);
            end
            if (job_puts == 0) first_put = cyc;
            job_puts++;
            last_put = cyc;
         end
         if (done) begin
            if (dq.size() == 0) begin
               fail_evt("unexpected_done");
            end else begin
               dexp_t de;
               de = dq.pop_front();
               chk("done_err", err, de.err);
               chk("words_left", exp_q.size(), 0);
               if (de.zero) chk("done_lat_zero", cyc, de.sc + 1);
               else         chk("done_lat", cyc, last_put + 1);
               if (burst_chk) chk("burst_len", last_put - first_put + 1, job_puts);
            end
            job_puts = 0;
         end
      end
   end

   task automatic run_job(input int dc, input int ek, input int extra, input bit restart, input bit burst);
      int    w, n, nload;
      dexp_t de;
      bit    ok;
      w = (dc + 7) >> 3;
      n = (ek > 0 && ek < w) ? ek : w;
      nload = (ek > 0) ? ((w < ek + 3) ? w : ek + 3) : ((w > 0) ? w + extra : 0);
      for (int i = 0; i < nload; i++) begin
         wexp_t s;
         s.d = {$urandom, $urandom};
         s.l = (ek > 0) ? (i == ek - 1) : (i == w - 1);
         src_q.push_back(s);
         if (i < n) begin
            wexp_t e;
            e.d = s.d;
            e.l = (i == n - 1);
            exp_q.push_back(e);
         end
      end
      burst_chk = burst;
      @(negedge clk);
      de.err  = (ek > 0 && ek < w);
      de.zero = (w == 0);
      de.sc   = cyc;
      dq.push_back(de);
      start = 1'b1;
      dc1_i = dc[23:0];
      @(negedge clk);
      start = 1'b0;
      if (restart) begin
         @(negedge clk);
         start = 1'b1;
         dc1_i = 24'd8;
         @(negedge clk);
         start = 1'b0;
      end
      ok = 0;
      for (int i = 0; i < 3000; i++) begin
         @(posedge clk);
         if (dq.size() == 0) begin
            ok = 1;
            break;
         end
      end
      if (!ok) begin
         total++;
         bad++;
         $display("FAIL job_timeout: dc1=%0d still waiting for done (cycle %0d)", dc, cyc);
         dq.delete();
         exp_q.delete();
      end
      repeat (2) @(negedge clk);
      src_q.delete();
      burst_chk = 0;
   endtask

   initial begin
      int cnt;
      rst = 1'b1;
      start = 1'b0;
      dc1_i = '0;
      m_reset1 = 1'b0;
      m_src = '0;
      m_src_last = 1'b0;
      m_src_almost_empty = 1'b0;
      m_dst_full = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_getn", m_src_getn, 1);
      chk("rst_putn", m_dst_putn, 1);
      chk("rst_last", m_dst_last, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      run_job(32, 0, 0, 0, 1);
      run_job(0, 0, 0, 0, 0);
      run_job(20, 0, 0, 0, 0);
      af_mode = 1;
      run_job(64, 0, 0, 1, 0);
      af_mode = 0;
      run_job(64, 3, 0, 0, 0);
      run_job(24'hffffff, 2, 0, 0, 0);

      // Abort after two words, then a fresh one-word job.
      for (int i = 0; i < 8; i++) begin
         wexp_t s;
         s.d = {$urandom, $urandom};
         s.l = (i == 7);
         src_q.push_back(s);
         if (i < 2) begin
            wexp_t e;
            e.d = s.d;
            e.l = 1'b0;
            exp_q.push_back(e);
         end
      end
      @(negedge clk);
      start = 1'b1;
      dc1_i = 24'd64;
      @(negedge clk);
      start = 1'b0;
      cnt = 0;
      for (int i = 0; i < 200; i++) begin
         if (!m_dst_putn) cnt++;
         if (cnt == 2) break;
         @(negedge clk);
      end
      chk("abort_reach", cnt, 2);
      m_reset1 = 1'b1;
      @(negedge clk);
      m_reset1 = 1'b0;
      chk("abort_putn", m_dst_putn, 1);
      chk("abort_getn", m_src_getn, 1);
      chk("abort_busy", busy, 0);
      repeat (6) @(negedge clk);
      chk("abort_words", exp_q.size(), 0);
      src_q.delete();
      exp_q.delete();
      job_puts = 0;
      run_job(8, 0, 0, 0, 0);

      // Asynchronous reset in the middle of a transfer.
      for (int i = 0; i < 8; i++) begin
         wexp_t s;
         s.d = {$urandom, $urandom};
         s.l = (i == 7);
         src_q.push_back(s);
         exp_q.push_back(s);
      end
      @(negedge clk);
      start = 1'b1;
      dc1_i = 24'd64;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      rst = 1'b1;
      #1;
      chk("arst_getn", m_src_getn, 1);
      chk("arst_putn", m_dst_putn, 1);
      chk("arst_busy", busy, 0);
      chk("arst_last", m_dst_last, 0);
      exp_q.delete();
      dq.delete();
      src_q.delete();
      job_puts = 0;
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      chk("arst_idle", busy, 0);

      af_mode = 2;
      stall_en = 1;
      for (int j = 0; j < 25; j++) begin
         int dc, w, ek;
         dc = $urandom_range(0, 120);
         w  = (dc + 7) >> 3;
         ek = (w > 0 && $urandom_range(0, 3) == 0) ? $urandom_range(1, w + 1) : 0;
         run_job(dc, ek, $urandom_range(0, 2), 0, 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
